// File: rtl/sd_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_xfer_pkg
// Brief    : Shared FSM encoding and block geometry for the SDRAM-to-SD saver.
// Revision : 1.0 - initial release
// ============================================================================
package sd_xfer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_FILL      = 3'd2,
    S_SD_WRITE  = 3'd3,
    S_NEXT      = 3'd4,
    S_COMPLITE  = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  localparam int unsigned WORDS_PER_BLOCK     = 128;
  localparam int unsigned HALFWORDS_PER_BLOCK = 256;
  localparam int unsigned SD_BLOCK_BYTES      = 512;
  localparam int unsigned WORD_AW             = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned HALF_AW             = $clog2(HALFWORDS_PER_BLOCK);

endpackage
`default_nettype wire

// File: rtl/sd_block_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sd_block_buffer
// Brief    : 128x32 staging RAM, 16-bit write port, registered 32-bit read port.
// Revision : 1.0 - initial release
// ============================================================================
module sd_block_buffer
  import sd_xfer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [HALF_AW-1:0] wr_addr,
  input  logic [15:0]        wr_data,
  input  logic               rd_en,
  input  logic [WORD_AW-1:0] rd_addr,
  output logic [31:0]        rd_data
);

  // Split halves so each array is a plain single-write-port RAM.
  logic [15:0] r_mem_lo [WORDS_PER_BLOCK];
  logic [15:0] r_mem_hi [WORDS_PER_BLOCK];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_addr[0]) begin
        r_mem_hi[wr_addr[HALF_AW-1:1]] <= wr_data;
      end else begin
        r_mem_lo[wr_addr[HALF_AW-1:1]] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= {r_mem_hi[rd_addr], r_mem_lo[rd_addr]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_to_sd_saver.sv
`default_nettype none
// ============================================================================
// Module   : sdram_to_sd_saver
// Brief    : Streams a contiguous SDRAM region to consecutive SD blocks.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_to_sd_saver
  import sd_xfer_pkg::*;
#(
  parameter logic [31:0] START_BLOCK     = 32'd0,
  parameter logic [31:0] BLOCK_COUNT     = 32'd1,
  parameter logic [23:0] SDRAM_BASE_ADDR = 24'd0,
  parameter logic [3:0]  MAX_RETRY       = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Save_En,
  output logic        Save_Complite,
  output logic        Save_Fail,
  input  logic        SD_Init_Complite,
  output logic        SD_Enable,
  output logic        SD_we,
  output logic [31:0] SD_Addr_Block,
  input  logic        SD_Complite,
  input  logic        SD_Fail,
  input  logic        SD_InPut_Data_Valid,
  input  logic [31:0] SD_InPut_Data_Addr,
  output logic [31:0] SD_InPut_Data,
  output logic        Serial_access_read,
  output logic        m_valid_read,
  output logic [23:0] m_addr_read,
  input  logic        m_ready_read,
  input  logic [15:0] m_out_data
);

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_blk_cnt;
  logic [3:0]         r_retry;
  logic [HALF_AW-1:0] r_hw_cnt;
  logic               r_sd_gap;

  logic w_capture;
  logic w_sd_live;
  logic w_sd_fail;
  logic w_sd_ok;
  logic w_fill_done;
  logic w_last_blk;
  logic w_rd_en;
  logic w_unused_addr_bits;

  assign w_capture   = (r_state == S_FILL) && m_ready_read;
  // r_sd_gap holds SD_Enable low for the single cycle between retry attempts.
  assign w_sd_live   = (r_state == S_SD_WRITE) && !r_sd_gap;
  assign w_sd_fail   = w_sd_live && SD_Fail;
  assign w_sd_ok     = w_sd_live && SD_Complite && !SD_Fail;
  assign w_fill_done = w_capture && (r_hw_cnt == HALF_AW'(HALFWORDS_PER_BLOCK - 1));
  assign w_last_blk  = (r_blk_cnt + 32'd1) == BLOCK_COUNT;
  assign w_rd_en     = (r_state == S_SD_WRITE) && SD_InPut_Data_Valid;
  assign w_unused_addr_bits = ^SD_InPut_Data_Addr[31:WORD_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    Serial_access_read = 1'b0;
    m_valid_read       = 1'b0;
    SD_Enable          = 1'b0;
    SD_we              = 1'b0;
    Save_Complite      = 1'b0;
    Save_Fail          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Save_En) w_state_next = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (SD_Init_Complite) w_state_next = S_FILL;
      end
      S_FILL: begin
        Serial_access_read = 1'b1;
        m_valid_read       = 1'b1;
        if (w_fill_done) w_state_next = S_SD_WRITE;
      end
      S_SD_WRITE: begin
        SD_Enable = w_sd_live;
        SD_we     = w_sd_live;
        if (w_sd_fail && (r_retry >= MAX_RETRY)) begin
          w_state_next = S_FAIL;
        end else if (w_sd_ok) begin
          w_state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        w_state_next = w_last_blk ? S_COMPLITE : S_FILL;
      end
      S_COMPLITE: begin
        Save_Complite = 1'b1;
        if (!Save_En) w_state_next = S_IDLE;
      end
      S_FAIL: begin
        Save_Fail = 1'b1;
        if (!Save_En) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SD_Addr_Block <= START_BLOCK;
      m_addr_read   <= SDRAM_BASE_ADDR;
      r_blk_cnt     <= 32'd0;
      r_retry       <= 4'd0;
      r_hw_cnt      <= '0;
      r_sd_gap      <= 1'b0;
    end else begin
      r_sd_gap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Save_En) begin
            SD_Addr_Block <= START_BLOCK;
            m_addr_read   <= SDRAM_BASE_ADDR;
            r_blk_cnt     <= 32'd0;
            r_retry       <= 4'd0;
            r_hw_cnt      <= '0;
          end
        end
        S_FILL: begin
          if (w_capture) begin
            m_addr_read <= m_addr_read + 24'd1;
            r_hw_cnt    <= r_hw_cnt + 1'b1;
          end
        end
        S_SD_WRITE: begin
          if (w_sd_fail && (r_retry < MAX_RETRY)) begin
            r_retry  <= r_retry + 4'd1;
            r_sd_gap <= 1'b1;
          end else if (w_sd_ok) begin
            r_retry <= 4'd0;
          end
        end
        S_NEXT: begin
          SD_Addr_Block <= SD_Addr_Block + 32'd1;
          r_blk_cnt     <= r_blk_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

  sd_block_buffer u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_capture),
    .wr_addr (r_hw_cnt),
    .wr_data (m_out_data),
    .rd_en   (w_rd_en),
    .rd_addr (SD_InPut_Data_Addr[WORD_AW-1:0]),
    .rd_data (SD_InPut_Data)
  );

endmodule
`default_nettype wire
